// File: rtl/dmi_req_guard_if.sv
// DMI link bundle around the request guard: DTM-side request/response and
// DM-side request/response handshakes.
interface dmi_req_guard_if;
    logic        up_req_valid_i;
    logic        up_req_ready_o;
    logic [6:0]  up_req_addr_i;
    logic [1:0]  up_req_op_i;
    logic [31:0] up_req_data_i;
    logic        up_resp_valid_o;
    logic        up_resp_ready_i;
    logic [31:0] up_resp_data_o;
    logic [1:0]  up_resp_code_o;
    logic        dm_req_valid_o;
    logic        dm_req_ready_i;
    logic [6:0]  dm_req_addr_o;
    logic [1:0]  dm_req_op_o;
    logic [31:0] dm_req_data_o;
    logic        dm_resp_valid_i;
    logic        dm_resp_ready_o;
    logic [31:0] dm_resp_data_i;
    logic [1:0]  dm_resp_code_i;

    modport slave (
        input  up_req_valid_i, up_req_addr_i, up_req_op_i, up_req_data_i,
        output up_req_ready_o,
        output up_resp_valid_o, up_resp_data_o, up_resp_code_o,
        input  up_resp_ready_i,
        output dm_req_valid_o, dm_req_addr_o, dm_req_op_o, dm_req_data_o,
        input  dm_req_ready_i,
        input  dm_resp_valid_i, dm_resp_data_i, dm_resp_code_i,
        output dm_resp_ready_o
    );

    modport master (
        output up_req_valid_i, up_req_addr_i, up_req_op_i, up_req_data_i,
        input  up_req_ready_o,
        input  up_resp_valid_o, up_resp_data_o, up_resp_code_o,
        output up_resp_ready_i,
        input  dm_req_valid_o, dm_req_addr_o, dm_req_op_o, dm_req_data_o,
        output dm_req_ready_i,
        output dm_resp_valid_i, dm_resp_data_i, dm_resp_code_i,
        input  dm_resp_ready_o
    );
endinterface

// File: rtl/dmi_req_guard.sv
// DMI request queue and response watchdog between the JTAG DTM and the debug
// module; a silent DM is answered with a failed response instead of hanging.
//
// state   | meaning
// S_IDLE  | may issue the FIFO head to the DM once the response slot is empty
// S_WAIT  | one request outstanding, watchdog running
// S_DRAIN | timed out; swallow one late DM response or wait out another window
module dmi_req_guard #(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmi_req_guard_if.slave bus,
    output logic           busy_o,
    output logic [7:0]     timeout_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = 7 + 2 + 32;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_ONE  = WW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    state_t        r_state;
    logic [WW-1:0] r_wdog;
    logic          r_resp_valid;
    logic [31:0]   r_resp_data;
    logic [1:0]    r_resp_code;
    logic [7:0]    r_timeout_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic          w_dm_req_valid;
    logic          w_dm_resp_ready;
    logic          w_dm_resp_hs;
    logic          w_wdog_last;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Only one DM transaction in flight, and never while a response waits for the DTM.
    assign w_dm_req_valid = (r_state == S_IDLE) && !w_empty && !r_resp_valid;
    assign w_push         = bus.up_req_valid_i && !w_full;
    assign w_pop          = w_dm_req_valid && bus.dm_req_ready_i;
    assign w_dm_resp_hs   = bus.dm_resp_valid_i && w_dm_resp_ready;
    assign w_wdog_last    = (r_wdog == WDOG_LAST);

    always_comb begin
        w_dm_resp_ready = 1'b0;
        case (r_state)
            S_WAIT:  w_dm_resp_ready = !r_resp_valid;
            S_DRAIN: w_dm_resp_ready = 1'b1;
            default: w_dm_resp_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {bus.up_req_addr_i, bus.up_req_op_i, bus.up_req_data_i};
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_wdog        <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_code   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (r_resp_valid && bus.up_resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the expiry cycle still wins.
                    if (w_dm_resp_hs) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= bus.dm_resp_data_i;
                        r_resp_code  <= bus.dm_resp_code_i;
                        r_state      <= S_IDLE;
                    end else if (w_wdog_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= '0;
                        r_resp_code  <= 2'd2;
                        if (r_timeout_cnt != 8'hFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                        r_wdog  <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_wdog <= r_wdog + WDOG_ONE;
                    end
                end
                S_DRAIN: begin
                    if (bus.dm_resp_valid_i || w_wdog_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.up_req_ready_o  = !w_full;
    assign bus.up_resp_valid_o = r_resp_valid;
    assign bus.up_resp_data_o  = r_resp_data;
    assign bus.up_resp_code_o  = r_resp_code;
    assign bus.dm_req_valid_o  = w_dm_req_valid;
    assign bus.dm_req_addr_o   = w_head[40:34];
    assign bus.dm_req_op_o     = w_head[33:32];
    assign bus.dm_req_data_o   = w_head[31:0];
    assign bus.dm_resp_ready_o = w_dm_resp_ready;
    assign busy_o              = (r_state != S_IDLE) || !w_empty;
    assign timeout_cnt_o       = r_timeout_cnt;
endmodule
